// File: rtl/display7_window_scroller.sv
// Seven-segment window scroller: shows NUM_DIGITS hex nibbles of a wide debug value
// starting at a wrapping nibble offset, with manual, auto-scroll, hold and blink modes.
module display7_window_scroller #(
    parameter int DATA_W     = 64,
    parameter int NUM_DIGITS = 6,
    parameter int SCROLL_DIV = 25_000_000,
    parameter int BLINK_DIV  = 12_500_000,
    localparam int NIBBLES   = DATA_W / 4,
    localparam int SEL_W     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1,
    localparam int SC_W      = $clog2(SCROLL_DIV),
    localparam int BL_W      = $clog2(BLINK_DIV)
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [DATA_W-1:0]       iOutput,
    input  logic [SEL_W-1:0]        iSelect,
    input  logic [1:0]              iMode,
    output logic [7*NUM_DIGITS-1:0] oHEX,
    output logic [SEL_W-1:0]        oWindow,
    output logic                    oStep
);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_SCROLL = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    mode_e                   mode_q, mode_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [SEL_W-1:0]        offset_q, offset_d;
    logic [SC_W-1:0]         scroll_cnt_q, scroll_cnt_d;
    logic [BL_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic                    blank_q, blank_d;
    logic                    step_q, step_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

    logic                    mode_chg;
    logic [SEL_W-1:0]        sel_wrapped;
    logic [SEL_W-1:0]        offset_inc;
    logic [7*NUM_DIGITS+6:0] hex_acc;
    logic [3:0]              nib;
    int                      idx;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        mode_chg     = (iMode != mode_q);
        mode_d       = mode_e'(iMode);
        data_d       = iOutput;
        offset_d     = offset_q;
        scroll_cnt_d = '0;
        blink_cnt_d  = '0;
        blank_d      = 1'b0;
        step_d       = 1'b0;

        // Select values past the last nibble (non power-of-two widths) fold back once.
        sel_wrapped = ({1'b0, iSelect} >= (SEL_W+1)'(NIBBLES)) ? iSelect - SEL_W'(NIBBLES) : iSelect;
        offset_inc  = (offset_q == SEL_W'(NIBBLES-1)) ? '0 : offset_q + SEL_W'(1);

        case (mode_d)
            MODE_MANUAL: offset_d = sel_wrapped;
            MODE_SCROLL: begin
                if (!mode_chg) begin
                    if (scroll_cnt_q == SC_W'(SCROLL_DIV-1)) begin
                        offset_d = offset_inc;
                        step_d   = 1'b1;
                    end else begin
                        scroll_cnt_d = scroll_cnt_q + SC_W'(1);
                    end
                end
            end
            MODE_HOLD:   data_d = data_q;
            default: begin
                offset_d = sel_wrapped;
                if (!mode_chg) begin
                    if (blink_cnt_q == BL_W'(BLINK_DIV-1)) begin
                        blank_d = ~blank_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BL_W'(1);
                        blank_d     = blank_q;
                    end
                end
            end
        endcase

        // Digits are shifted in from the top so digit 0 ends up in the lowest slot.
        hex_acc = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            idx = int'(offset_q) + k;
            if (idx >= NIBBLES) idx = idx - NIBBLES;
            nib     = 4'(data_q >> (4 * idx));
            hex_acc = {(blank_q ? 7'h7f : seg7(nib)), hex_acc[7*NUM_DIGITS+6:7]};
        end
        hex_d = hex_acc[7*NUM_DIGITS+6:7];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mode_q       <= MODE_MANUAL;
            data_q       <= '0;
            offset_q     <= '0;
            scroll_cnt_q <= '0;
            blink_cnt_q  <= '0;
            blank_q      <= 1'b0;
            step_q       <= 1'b0;
            hex_q        <= '1;
        end else begin
            mode_q       <= mode_d;
            data_q       <= data_d;
            offset_q     <= offset_d;
            scroll_cnt_q <= scroll_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blank_q      <= blank_d;
            step_q       <= step_d;
            hex_q        <= hex_d;
        end
    end

    assign oHEX    = hex_q;
    assign oWindow = offset_q;
    assign oStep   = step_q;

endmodule
